// File: rtl/cache_axi_master_pkg.sv
// Shared definitions for the cache-to-AXI bridge.
// Holds the AXI burst/size encodings, the cache request type codes, the
// read/write FSM state types and helpers that turn a cache request type into
// AXI address/len/size fields.
package cache_axi_master_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [7:0] LEN_LINE   = 8'd3;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wr_state_e;

  // Uncached accesses carry their width in the low two type bits.
  function automatic logic [2:0] axi_size(input logic [2:0] t);
    return (t == TYPE_LINE) ? SIZE_4B : {1'b0, t[1:0]};
  endfunction

  function automatic logic [7:0] axi_len(input logic [2:0] t);
    return (t == TYPE_LINE) ? LEN_LINE : LEN_SINGLE;
  endfunction

  // Line bursts always start at the 16-byte line boundary.
  function automatic logic [31:0] axi_addr(input logic [2:0] t, input logic [31:0] a);
    return (t == TYPE_LINE) ? {a[31:4], 4'b0000} : a;
  endfunction

endpackage

// File: rtl/cache_axi_master_if.sv
// AXI4 master-side channel bundle (AR/R/AW/W/B) used by cache_axi_master.
// master: driven by the bridge; slave: driven by the interconnect side.
// Lock/cache/prot/qos are tied off outside this block and are not carried.
interface cache_axi_master_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_wr_ch.sv
// Write channel of the cache-to-AXI bridge: one outstanding write.
// Captures the request into a 128-bit buffer, issues AW and W independently,
// then waits for B and pulses wr_resp.
// Ports: clk/resetn; cache write request (wr_req/type/addr/wstrb/data,
// wr_rdy, wr_resp); busy + line_addr for the read-side hazard check;
// AXI AW/W/B channel signals.
//
// state  | meaning
// W_IDLE | no write outstanding, wr_rdy high
// W_SEND | AW and/or W still outstanding
// W_RESP | both sent, bready high waiting for B
module cache_axi_wr_ch
  import cache_axi_master_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_resp,
  output logic         busy,
  output logic [27:0]  line_addr,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  wr_state_e      state, state_nxt;
  logic [31:0]    wbuf_addr;
  logic [2:0]     wbuf_type;
  logic [3:0]     wbuf_wstrb;
  logic [127:0]   wbuf_data;
  logic [1:0]     cnt;
  logic           aw_done, w_done;
  logic           in_send, is_line;
  logic           aw_hs, w_hs, w_last_hs;

  assign in_send   = (state == W_SEND);
  assign is_line   = (wbuf_type == TYPE_LINE);

  assign awvalid   = in_send & ~aw_done;
  assign wvalid    = in_send & ~w_done;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign w_last_hs = w_hs & wlast;

  assign awid      = WR_ID;
  assign awaddr    = axi_addr(wbuf_type, wbuf_addr);
  assign awlen     = axi_len(wbuf_type);
  assign awsize    = axi_size(wbuf_type);
  assign awburst   = BURST_INCR;

  assign wdata     = is_line ? wbuf_data[{cnt, 5'd0} +: 32] : wbuf_data[31:0];
  assign wstrb     = is_line ? 4'hF : wbuf_wstrb;
  assign wlast     = is_line ? (cnt == 2'd3) : 1'b1;

  assign wr_resp   = bvalid & bready;
  assign busy      = (state != W_IDLE);
  assign line_addr = wbuf_addr[31:4];

  always_ff @(posedge clk) begin
    if (!resetn) state <= W_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_rdy    = 1'b0;
    bready    = 1'b0;
    case (state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) state_nxt = W_SEND;
      end
      W_SEND: begin
        // AW and W may finish in either order or together.
        if ((aw_done | aw_hs) & (w_done | w_last_hs)) state_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_req & wr_rdy) begin
      wbuf_addr  <= wr_addr;
      wbuf_type  <= wr_type;
      wbuf_wstrb <= wr_wstrb;
      wbuf_data  <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= 2'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_req & wr_rdy) begin
      cnt     <= 2'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs)     aw_done <= 1'b1;
      if (w_hs)      cnt     <= cnt + 2'd1;
      if (w_last_hs) w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_axi_master.sv
// Cache-to-AXI4 master bridge. One outstanding read and one outstanding
// write, independent of each other. Line accesses use 4-beat INCR bursts,
// uncached accesses single beats.
// Ports: clk/resetn; cache read side (rd_req/type/addr, rd_rdy, ret_valid/
// last/data); cache write side (wr_req/type/addr/wstrb/data, wr_rdy,
// wr_resp); axi: AXI4 master channels AR/R/AW/W/B.
//
// state  | meaning
// R_IDLE | no read outstanding, rd_rdy unless line hazard
// R_AR   | arvalid high waiting for arready
// R_DATA | rready high, beats forwarded until rlast
module cache_axi_master
  import cache_axi_master_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rd_req,
  input  logic [2:0]         rd_type,
  input  logic [31:0]        rd_addr,
  output logic               rd_rdy,
  output logic               ret_valid,
  output logic               ret_last,
  output logic [31:0]        ret_data,
  input  logic               wr_req,
  input  logic [2:0]         wr_type,
  input  logic [31:0]        wr_addr,
  input  logic [3:0]         wr_wstrb,
  input  logic [127:0]       wr_data,
  output logic               wr_rdy,
  output logic               wr_resp,
  cache_axi_master_if.master axi
);

  rd_state_e    rd_state, rd_state_nxt;
  logic [31:0]  rd_addr_q;
  logic [2:0]   rd_type_q;
  logic         arvalid_int, rready_int;
  logic         wr_busy;
  logic [27:0]  wr_line;
  logic         hazard;
  logic         unused_axi;

  // A read of the line the write buffer is still pushing out would return
  // stale data from memory, so hold it until the write completes.
  assign hazard = wr_busy & (rd_addr[31:4] == wr_line);

  always_ff @(posedge clk) begin
    if (!resetn) rd_state <= R_IDLE;
    else         rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_rdy       = 1'b0;
    arvalid_int  = 1'b0;
    rready_int   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        rd_rdy = ~hazard;
        if (rd_req & ~hazard) rd_state_nxt = R_AR;
      end
      R_AR: begin
        arvalid_int = 1'b1;
        if (axi.arready) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready_int = 1'b1;
        if (axi.rvalid & axi.rlast) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rd_req & rd_rdy) begin
      rd_addr_q <= rd_addr;
      rd_type_q <= rd_type;
    end
  end

  assign axi.arid    = RD_ID;
  assign axi.araddr  = axi_addr(rd_type_q, rd_addr_q);
  assign axi.arlen   = axi_len(rd_type_q);
  assign axi.arsize  = axi_size(rd_type_q);
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = arvalid_int;
  assign axi.rready  = rready_int;

  assign ret_valid = axi.rvalid & rready_int;
  assign ret_last  = axi.rvalid & rready_int & axi.rlast;
  assign ret_data  = axi.rdata;

  // Response codes and IDs are not acted on.
  assign unused_axi = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  cache_axi_wr_ch #(
    .WR_ID (WR_ID)
  ) u_wr_ch (
    .clk       (clk),
    .resetn    (resetn),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .wr_resp   (wr_resp),
    .busy      (wr_busy),
    .line_addr (wr_line),
    .awid      (axi.awid),
    .awaddr    (axi.awaddr),
    .awlen     (axi.awlen),
    .awsize    (axi.awsize),
    .awburst   (axi.awburst),
    .awvalid   (axi.awvalid),
    .awready   (axi.awready),
    .wdata     (axi.wdata),
    .wstrb     (axi.wstrb),
    .wlast     (axi.wlast),
    .wvalid    (axi.wvalid),
    .wready    (axi.wready),
    .bvalid    (axi.bvalid),
    .bready    (axi.bready)
  );

endmodule

// File: tb/tb_cache_axi_master.sv
// Self-checking bench for cache_axi_master. Expected read beats and write
// beats are queued when stimulus is set up and popped as the DUT emits them.
module tb_cache_axi_master;
  import cache_axi_master_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'd0;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'd0;
  logic [31:0]  wr_addr = 32'd0;
  logic [3:0]   wr_wstrb = 4'd0;
  logic [127:0] wr_data = 128'd0;
  logic         wr_rdy, wr_resp;

  int total = 0;
  int bad = 0;

  logic [32:0] rq[$];   // {last, data}
  logic [36:0] wq[$];   // {last, strb, data}

  cache_axi_master_if axi ();

  cache_axi_master dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .wr_resp   (wr_resp),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    settle;
    total++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, wr_resp, ret_valid, rd_rdy, wr_rdy} !== 9'b000000011) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, wr_resp, ret_valid, rd_rdy, wr_rdy}, 9'b000000011);
    end
  endtask

  task automatic test_line_read;
    int cyc;
    int beat;
    logic [32:0] e;
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h1FC0_0014;
    settle;
    total++;
    if (rd_rdy !== 1'b1) begin bad++; $display("FAIL lr_rd_rdy got=%b exp=1", rd_rdy); end
    tick;
    settle;
    total++;
    if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid} !== {1'b1, 32'h1FC0_0010, 8'd3, 3'd2, 2'b01, 4'd0}) begin
      bad++;
      $display("FAIL lr_ar got=%b/%h/%0d/%0d/%0d/%0d exp=1/1fc00010/3/2/1/0", axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid);
    end
    tick;
    settle;
    total++;
    if ({axi.arvalid, axi.araddr} !== {1'b1, 32'h1FC0_0010}) begin
      bad++; $display("FAIL lr_ar_hold got=%b/%h exp=1/1fc00010", axi.arvalid, axi.araddr);
    end
    tick;
    axi.arready = 1'b1;
    settle;
    tick;
    axi.arready = 1'b0;
    for (int i = 0; i < 4; i++) rq.push_back({(i == 3), 32'hA0 + 32'(i)});
    cyc = 0; beat = 0;
    while (rq.size() > 0 && cyc < 20) begin
      axi.rvalid = (beat < 4);
      axi.rdata  = 32'hA0 + 32'(beat);
      axi.rlast  = (beat == 3);
      settle;
      if (ret_valid) begin
        e = rq.pop_front();
        total++;
        if ({ret_last, ret_data} !== e) begin
          bad++; $display("FAIL lr_beat got=%b/%h exp=%b/%h", ret_last, ret_data, e[32], e[31:0]);
        end
      end
      if (axi.rvalid && axi.rready) beat++;
      tick;
      cyc++;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_req = 1'b0;
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL lr_timeout got=%0d exp=0 beats left", rq.size()); rq.delete(); end
    settle;
    total++;
    if ({rd_rdy, axi.arvalid, axi.rready} !== 3'b100) begin
      bad++; $display("FAIL lr_idle got=%b exp=100", {rd_rdy, axi.arvalid, axi.rready});
    end
  endtask

  task automatic test_word_read;
    int cyc;
    bit sent;
    bit rready_drop;
    bit ghost;
    logic [32:0] e;
    rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_1004;
    settle;
    tick;
    rd_req = 1'b0;
    settle;
    total++;
    if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize} !== {1'b1, 32'h0000_1004, 8'd0, 3'd2}) begin
      bad++; $display("FAIL wr_ar got=%b/%h/%0d/%0d exp=1/00001004/0/2", axi.arvalid, axi.araddr, axi.arlen, axi.arsize);
    end
    axi.arready = 1'b1;
    tick;
    axi.arready = 1'b0;
    rq.push_back({1'b1, 32'hCAFE_1004});
    cyc = 0; sent = 0; rready_drop = 0; ghost = 0;
    while (rq.size() > 0 && cyc < 12) begin
      axi.rvalid = (cyc >= 3) && !sent;
      axi.rdata  = axi.rvalid ? 32'hCAFE_1004 : 32'h0BAD_0BAD;
      axi.rlast  = axi.rvalid;
      settle;
      if (axi.rready !== 1'b1) rready_drop = 1;
      if (!axi.rvalid && ret_valid) ghost = 1;
      if (ret_valid) begin
        e = rq.pop_front();
        total++;
        if ({ret_last, ret_data} !== e) begin
          bad++; $display("FAIL wrd_beat got=%b/%h exp=%b/%h", ret_last, ret_data, e[32], e[31:0]);
        end
      end
      if (axi.rvalid && axi.rready) sent = 1;
      tick;
      cyc++;
    end
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL wrd_timeout got=%0d exp=0 beats left", rq.size()); rq.delete(); end
    total++;
    if ({rready_drop, ghost} !== 2'b00) begin bad++; $display("FAIL wrd_gap got=%b exp=00 (rready_drop,ghost)", {rready_drop, ghost}); end
    settle;
    total++;
    if (rd_rdy !== 1'b1) begin bad++; $display("FAIL wrd_idle got=%b exp=1", rd_rdy); end
  endtask

  task automatic test_line_write;
    int cyc;
    bit aw_seen;
    bit bready_early;
    logic [36:0] e;
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 32'hD0D0_D000 + 32'(i);
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h8000_0020; wr_wstrb = 4'h0;
    wr_data = {d[3], d[2], d[1], d[0]};
    settle;
    total++;
    if (wr_rdy !== 1'b1) begin bad++; $display("FAIL lw_wr_rdy got=%b exp=1", wr_rdy); end
    for (int i = 0; i < 4; i++) wq.push_back({(i == 3), 4'hF, d[i]});
    tick;
    wr_req = 1'b0;
    cyc = 0; aw_seen = 0; bready_early = 0;
    while ((wq.size() > 0 || !aw_seen) && cyc < 40) begin
      axi.wready  = (cyc % 2 == 1);
      axi.awready = (wq.size() == 0);
      settle;
      if (axi.bready) bready_early = 1;
      if (axi.wvalid && axi.wready) begin
        total++;
        if (wq.size() > 0) begin
          e = wq.pop_front();
          if ({axi.wlast, axi.wstrb, axi.wdata} !== e) begin
            bad++; $display("FAIL lw_beat got=%b/%h/%h exp=%b/%h/%h", axi.wlast, axi.wstrb, axi.wdata, e[36], e[35:32], e[31:0]);
          end
        end else begin
          bad++; $display("FAIL lw_extra_beat got=%h exp=none", axi.wdata);
        end
      end
      if (axi.awvalid && axi.awready) begin
        aw_seen = 1;
        total++;
        if ({axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid} !== {32'h8000_0020, 8'd3, 3'd2, 2'b01, 4'd1}) begin
          bad++; $display("FAIL lw_aw got=%h/%0d/%0d/%0d/%0d exp=80000020/3/2/1/1", axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid);
        end
      end
      tick;
      cyc++;
    end
    axi.wready = 1'b0; axi.awready = 1'b0;
    total++;
    if (wq.size() != 0 || !aw_seen) begin bad++; $display("FAIL lw_timeout got=%0d/%b exp=0/1 (beats left, aw)", wq.size(), aw_seen); wq.delete(); end
    total++;
    if (bready_early !== 1'b0) begin bad++; $display("FAIL lw_bready_early got=1 exp=0"); end
    settle;
    total++;
    if ({axi.bready, wr_resp} !== 2'b10) begin bad++; $display("FAIL lw_wait_b got=%b exp=10", {axi.bready, wr_resp}); end
    tick;
    axi.bvalid = 1'b1;
    settle;
    total++;
    if (wr_resp !== 1'b1) begin bad++; $display("FAIL lw_resp got=%b exp=1", wr_resp); end
    tick;
    axi.bvalid = 1'b0;
    settle;
    total++;
    if ({wr_resp, axi.bready, wr_rdy} !== 3'b001) begin bad++; $display("FAIL lw_resp_end got=%b exp=001", {wr_resp, axi.bready, wr_rdy}); end
  endtask

  task automatic test_byte_write;
    logic [36:0] e;
    wr_req = 1'b1; wr_type = TYPE_BYTE; wr_addr = 32'h8000_0003; wr_wstrb = 4'b1000;
    wr_data = {96'hDEAD_BEEF_1234_5678_9ABC_DEF0, 32'hAB00_0000};
    wq.push_back({1'b1, 4'h8, 32'hAB00_0000});
    settle;
    tick;
    wr_req = 1'b0;
    axi.awready = 1'b1; axi.wready = 1'b1;
    settle;
    total++;
    if ({axi.awvalid, axi.awaddr, axi.awlen, axi.awsize} !== {1'b1, 32'h8000_0003, 8'd0, 3'd0}) begin
      bad++; $display("FAIL bw_aw got=%b/%h/%0d/%0d exp=1/80000003/0/0", axi.awvalid, axi.awaddr, axi.awlen, axi.awsize);
    end
    total++;
    if (axi.wvalid && wq.size() > 0) begin
      e = wq.pop_front();
      if ({axi.wlast, axi.wstrb, axi.wdata} !== e) begin
        bad++; $display("FAIL bw_beat got=%b/%h/%h exp=%b/%h/%h", axi.wlast, axi.wstrb, axi.wdata, e[36], e[35:32], e[31:0]);
      end
    end else begin
      bad++; $display("FAIL bw_beat got=wvalid %b exp=wvalid 1", axi.wvalid);
      wq.delete();
    end
    tick;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1;
    settle;
    total++;
    if ({axi.awvalid, axi.wvalid, axi.bready, wr_resp} !== 4'b0011) begin
      bad++; $display("FAIL bw_resp got=%b exp=0011", {axi.awvalid, axi.wvalid, axi.bready, wr_resp});
    end
    tick;
    axi.bvalid = 1'b0;
    settle;
    total++;
    if ({wr_resp, wr_rdy} !== 2'b01) begin bad++; $display("FAIL bw_idle got=%b exp=01", {wr_resp, wr_rdy}); end
  endtask

  task automatic test_hazard;
    int cyc;
    bit leak;
    logic [32:0] e;
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h8000_0040; wr_wstrb = 4'h0;
    wr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    settle;
    tick;
    wr_req = 1'b0;
    rd_req = 1'b1; rd_type = TYPE_HALF; rd_addr = 32'h8000_0048;
    settle;
    total++;
    if (rd_rdy !== 1'b0) begin bad++; $display("FAIL hz_block got=%b exp=0", rd_rdy); end
    tick;
    settle;
    total++;
    if ({rd_rdy, axi.arvalid} !== 2'b00) begin bad++; $display("FAIL hz_block2 got=%b exp=00", {rd_rdy, axi.arvalid}); end
    rd_addr = 32'h8000_0080;
    settle;
    total++;
    if (rd_rdy !== 1'b1) begin bad++; $display("FAIL hz_other_line got=%b exp=1", rd_rdy); end
    tick;
    rd_req = 1'b0;
    settle;
    total++;
    if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize} !== {1'b1, 32'h8000_0080, 8'd0, 3'd1}) begin
      bad++; $display("FAIL hz_ar got=%b/%h/%0d/%0d exp=1/80000080/0/1", axi.arvalid, axi.araddr, axi.arlen, axi.arsize);
    end
    axi.arready = 1'b1;
    tick;
    axi.arready = 1'b0;
    rq.push_back({1'b1, 32'h5A5A_0080});
    axi.rvalid = 1'b1; axi.rdata = 32'h5A5A_0080; axi.rlast = 1'b1;
    settle;
    total++;
    if (ret_valid) begin
      e = rq.pop_front();
      if ({ret_last, ret_data} !== e) begin
        bad++; $display("FAIL hz_beat got=%b/%h exp=%b/%h", ret_last, ret_data, e[32], e[31:0]);
      end
    end else begin
      bad++; $display("FAIL hz_beat got=ret_valid 0 exp=ret_valid 1");
      rq.delete();
    end
    tick;
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h8000_0048;
    axi.awready = 1'b1; axi.wready = 1'b1;
    settle;
    cyc = 0; leak = 0;
    while (!axi.bready && cyc < 12) begin
      if (rd_rdy) leak = 1;
      tick;
      settle;
      cyc++;
    end
    axi.awready = 1'b0; axi.wready = 1'b0;
    total++;
    if (axi.bready !== 1'b1) begin bad++; $display("FAIL hz_wr_timeout got=bready %b exp=1", axi.bready); end
    total++;
    if ({leak, rd_rdy} !== 2'b00) begin bad++; $display("FAIL hz_leak got=%b exp=00", {leak, rd_rdy}); end
    tick;
    axi.bvalid = 1'b1;
    settle;
    total++;
    if ({wr_resp, rd_rdy} !== 2'b10) begin bad++; $display("FAIL hz_resp got=%b exp=10", {wr_resp, rd_rdy}); end
    tick;
    axi.bvalid = 1'b0;
    settle;
    total++;
    if (rd_rdy !== 1'b1) begin bad++; $display("FAIL hz_release got=%b exp=1", rd_rdy); end
    rd_req = 1'b0;
    settle;
  endtask

  task automatic test_reset_mid;
    logic [32:0] e;
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h0000_0100;
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h0000_0200;
    settle;
    total++;
    if ({rd_rdy, wr_rdy} !== 2'b11) begin bad++; $display("FAIL rm_dual_accept got=%b exp=11", {rd_rdy, wr_rdy}); end
    tick;
    rd_req = 1'b0; wr_req = 1'b0;
    axi.arready = 1'b1;
    settle;
    tick;
    axi.arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq.push_back({1'b0, 32'h0000_0B00 + 32'(i)});
      axi.rvalid = 1'b1; axi.rdata = 32'h0000_0B00 + 32'(i); axi.rlast = 1'b0;
      settle;
      total++;
      if (ret_valid && rq.size() > 0) begin
        e = rq.pop_front();
        if ({ret_last, ret_data} !== e) begin
          bad++; $display("FAIL rm_beat got=%b/%h exp=%b/%h", ret_last, ret_data, e[32], e[31:0]);
        end
      end else begin
        bad++; $display("FAIL rm_beat got=ret_valid %b exp=1", ret_valid);
        rq.delete();
      end
      tick;
    end
    axi.rdata = 32'h0000_0B02;
    resetn = 1'b0;
    settle;
    tick;
    resetn = 1'b1;
    axi.rvalid = 1'b0;
    settle;
    total++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, wr_resp, ret_valid, rd_rdy, wr_rdy} !== 9'b000000011) begin
      bad++;
      $display("FAIL rm_after_reset got=%b exp=%b", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, wr_resp, ret_valid, rd_rdy, wr_rdy}, 9'b000000011);
    end
  endtask

  initial begin
    axi.arready = 1'b0;
    axi.rid = 4'd0; axi.rdata = 32'd0; axi.rresp = 2'd0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bid = 4'd1; axi.bresp = 2'd0; axi.bvalid = 1'b0;

    test_reset;
    test_line_read;
    test_word_read;
    test_line_write;
    test_byte_write;
    test_hazard;
    test_reset_mid;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
